// File: rtl/mc_control_unit_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_control_unit_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction fields in, datapath control strobes out, between control unit and datapath.
// Latency: n/a (wiring only).
// Backpressure: mem_ready is the only stall input.
interface mc_control_unit_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         f3;
    logic               f7;
    logic               zero;
    logic               mem_ready;

    logic               pcWrite;
    logic               adrSrc;
    logic               memRead;
    logic               memWrite;
    logic               irWrite;
    logic [1:0]         resSrc;
    logic [1:0]         aluSrcA;
    logic [1:0]         aluSrcB;
    logic [2:0]         ALUControl;
    logic               regWrite;
    logic [1:0]         inmSrc;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, f3, f7, zero, mem_ready,
        output pcWrite, adrSrc, memRead, memWrite, irWrite, resSrc,
               aluSrcA, aluSrcB, ALUControl, regWrite, inmSrc, illegal, state
    );

    modport slave (
        output op, f3, f7, zero, mem_ready,
        input  pcWrite, adrSrc, memRead, memWrite, irWrite, resSrc,
               aluSrcA, aluSrcB, ALUControl, regWrite, inmSrc, illegal, state
    );
endinterface

// File: rtl/alu_deco.sv
// ALU operation decode from funct3/funct7 for R-type and I-type ALU instructions.
// Latency: combinational.
// Backpressure: none.
module alu_deco
    import mc_control_unit_pkg::*;
(
    input  logic [2:0] f3,
    input  logic       f7,
    input  logic       isR,
    output logic [2:0] ALUControl,
    output logic       bad
);
    always_comb begin
        ALUControl = ALU_ADD;
        bad        = 1'b0;
        case (f3)
            3'b000:  ALUControl = (isR && f7) ? ALU_SUB : ALU_ADD;  // addi has no sub form
            3'b010:  ALUControl = ALU_SLT;
            3'b110:  ALUControl = ALU_OR;
            3'b111:  ALUControl = ALU_AND;
            default: bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM: lw/sw/R/I-ALU/beq/bne/jal, sticky trap on illegal encodings.
// Latency: 3-5 cycles per instruction, plus mem_ready stalls when MEM_WAIT=1.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold with write enables off until mem_ready.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b0,
    parameter bit HAS_BNE  = 1'b1,
    parameter int STATE_W  = 4
) (
    input  logic               clk_RV,
    input  logic               reset_RV,
    mc_control_unit_if.master  bus
);
    state_e     state_q;
    logic       illegal_q;
    logic       mem_go;
    logic       is_sw;
    logic       br_legal;
    logic       br_take;
    logic       alu_bad;
    logic [2:0] alu_ctl;

    logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, adr_src;
    logic [1:0] res_src, src_a, src_b, imm_src;
    logic [2:0] alu_op;

    assign mem_go   = !MEM_WAIT || bus.mem_ready;
    assign is_sw    = (bus.op == OP_SW);
    assign br_legal = (bus.f3 == 3'b000) || (HAS_BNE && (bus.f3 == 3'b001));
    assign br_take  = (bus.f3 == 3'b000) ? bus.zero : !bus.zero;

    alu_deco u_alu_deco (
        .f3         (bus.f3),
        .f7         (bus.f7),
        .isR        (state_q == EXECR),
        .ALUControl (alu_ctl),
        .bad        (alu_bad)
    );

    // illegal is raised on the same edge that enters TRAP so it is valid in TRAP's first cycle
    always_ff @(posedge clk_RV) begin
        if (reset_RV) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH:    if (mem_go) state_q <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_R:         state_q <= EXECR;
                        OP_I:         state_q <= EXECI;
                        OP_BR:        state_q <= BRANCH;
                        OP_JAL:       state_q <= JAL;
                        default: begin
                            state_q   <= TRAP;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                MEMADR:   state_q <= is_sw ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem_go) state_q <= MEMWB;
                MEMWB:    state_q <= FETCH;
                MEMWRITE: if (mem_go) state_q <= FETCH;
                EXECR, EXECI: begin
                    if (alu_bad) begin
                        state_q   <= TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q   <= ALUWB;
                    end
                end
                ALUWB:    state_q <= FETCH;
                BRANCH: begin
                    if (br_legal) begin
                        state_q   <= FETCH;
                    end else begin
                        state_q   <= TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                JAL:      state_q <= ALUWB;
                default: begin
                    state_q   <= TRAP;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        reg_wr  = 1'b0;
        adr_src = 1'b0;
        res_src = RES_ALUOUT;
        src_a   = SRCA_PC;
        src_b   = SRCB_RS2;
        alu_op  = ALU_ADD;
        imm_src = IMM_I;
        case (state_q)
            FETCH: begin
                mem_rd  = 1'b1;
                src_b   = SRCB_FOUR;
                res_src = RES_ALURES;
                ir_wr   = mem_go;
                pc_wr   = mem_go;
            end
            DECODE: begin
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_IMM;
                imm_src = IMM_B;
            end
            MEMADR: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                imm_src = is_sw ? IMM_S : IMM_I;
            end
            MEMREAD: begin
                mem_rd  = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                res_src = RES_DATA;
                reg_wr  = 1'b1;
            end
            MEMWRITE: begin
                mem_wr  = 1'b1;
                adr_src = 1'b1;
            end
            EXECR: begin
                src_a   = SRCA_RS1;
                alu_op  = alu_ctl;
            end
            EXECI: begin
                src_a   = SRCA_RS1;
                src_b   = SRCB_IMM;
                alu_op  = alu_ctl;
            end
            ALUWB:    reg_wr = 1'b1;
            BRANCH: begin
                src_a   = SRCA_RS1;
                alu_op  = ALU_SUB;
                pc_wr   = br_legal && br_take;
            end
            JAL: begin
                src_a   = SRCA_OLDPC;
                src_b   = SRCB_FOUR;
                pc_wr   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pcWrite    = pc_wr  && !reset_RV;
    assign bus.irWrite    = ir_wr  && !reset_RV;
    assign bus.memRead    = mem_rd && !reset_RV;
    assign bus.memWrite   = mem_wr && !reset_RV;
    assign bus.regWrite   = reg_wr && !reset_RV;
    assign bus.adrSrc     = adr_src;
    assign bus.resSrc     = res_src;
    assign bus.aluSrcA    = src_a;
    assign bus.aluSrcB    = src_b;
    assign bus.ALUControl = alu_op;
    assign bus.inmSrc     = imm_src;
    assign bus.illegal    = illegal_q;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench: two control units (MEM_WAIT=0/HAS_BNE=1 and MEM_WAIT=1/HAS_BNE=0)
// share instruction stimulus; every cycle's full control vector is compared.
// Backpressure exercised through mem_ready on the MEM_WAIT=1 instance.
module tb_mc_control_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_control_unit_if #(.STATE_W(4)) bus_a ();
    mc_control_unit_if #(.STATE_W(4)) bus_b ();

    mc_control_unit #(.MEM_WAIT(1'b0), .HAS_BNE(1'b1), .STATE_W(4)) u_a (
        .clk_RV   (clk),
        .reset_RV (rst),
        .bus      (bus_a.master)
    );

    mc_control_unit #(.MEM_WAIT(1'b1), .HAS_BNE(1'b0), .STATE_W(4)) u_b (
        .clk_RV   (clk),
        .reset_RV (rst),
        .bus      (bus_b.master)
    );

    wire [21:0] obs_a = {bus_a.state, bus_a.illegal, bus_a.pcWrite, bus_a.adrSrc, bus_a.memRead,
                         bus_a.memWrite, bus_a.irWrite, bus_a.resSrc, bus_a.aluSrcA, bus_a.aluSrcB,
                         bus_a.ALUControl, bus_a.regWrite, bus_a.inmSrc};
    wire [21:0] obs_b = {bus_b.state, bus_b.illegal, bus_b.pcWrite, bus_b.adrSrc, bus_b.memRead,
                         bus_b.memWrite, bus_b.irWrite, bus_b.resSrc, bus_b.aluSrcA, bus_b.aluSrcB,
                         bus_b.ALUControl, bus_b.regWrite, bus_b.inmSrc};

    typedef struct packed {
        logic [7:0] tid;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       mr;
    } stim_t;

    stim_t       sq[$];
    logic [21:0] qa[$];
    logic [21:0] qb[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] cur_tid;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       cur_zero;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {state, illegal, pcWrite, adrSrc, memRead, memWrite, irWrite, resSrc, aluSrcA, aluSrcB, ALUControl, regWrite, inmSrc}
    function automatic logic [21:0] ev(input logic [3:0] st, input logic ill, input logic pcw,
                                       input logic adr, input logic mr, input logic mw, input logic irw,
                                       input logic [1:0] res, input logic [1:0] asa, input logic [1:0] asb,
                                       input logic [2:0] alu, input logic rw, input logic [1:0] imm);
        return {st, ill, pcw, adr, mr, mw, irw, res, asa, asb, alu, rw, imm};
    endfunction

    function automatic logic [21:0] e_f();      return ev(4'd0, 0,1,0,1,0,1, 2'b10,2'b00,2'b10,3'b000,0,2'b00); endfunction
    function automatic logic [21:0] e_fstall(); return ev(4'd0, 0,0,0,1,0,0, 2'b10,2'b00,2'b10,3'b000,0,2'b00); endfunction
    function automatic logic [21:0] e_frst();   return ev(4'd0, 0,0,0,0,0,0, 2'b10,2'b00,2'b10,3'b000,0,2'b00); endfunction
    function automatic logic [21:0] e_d();      return ev(4'd1, 0,0,0,0,0,0, 2'b00,2'b01,2'b01,3'b000,0,2'b10); endfunction
    function automatic logic [21:0] e_madr(input logic sw);
        return ev(4'd2, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,3'b000,0, sw ? 2'b01 : 2'b00);
    endfunction
    function automatic logic [21:0] e_mrd();    return ev(4'd3, 0,0,1,1,0,0, 2'b00,2'b00,2'b00,3'b000,0,2'b00); endfunction
    function automatic logic [21:0] e_mwb();    return ev(4'd4, 0,0,0,0,0,0, 2'b01,2'b00,2'b00,3'b000,1,2'b00); endfunction
    function automatic logic [21:0] e_mwr();    return ev(4'd5, 0,0,1,0,1,0, 2'b00,2'b00,2'b00,3'b000,0,2'b00); endfunction
    function automatic logic [21:0] e_exr(input logic [2:0] alu);
        return ev(4'd6, 0,0,0,0,0,0, 2'b00,2'b10,2'b00,alu,0,2'b00);
    endfunction
    function automatic logic [21:0] e_exi(input logic [2:0] alu);
        return ev(4'd7, 0,0,0,0,0,0, 2'b00,2'b10,2'b01,alu,0,2'b00);
    endfunction
    function automatic logic [21:0] e_awb();    return ev(4'd8, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,3'b000,1,2'b00); endfunction
    function automatic logic [21:0] e_br(input logic pcw);
        return ev(4'd9, 0,pcw,0,0,0,0, 2'b00,2'b10,2'b00,3'b001,0,2'b00);
    endfunction
    function automatic logic [21:0] e_jal();    return ev(4'd10,0,1,0,0,0,0, 2'b00,2'b01,2'b10,3'b000,0,2'b00); endfunction
    function automatic logic [21:0] e_trap();   return ev(4'd11,1,0,0,0,0,0, 2'b00,2'b00,2'b00,3'b000,0,2'b00); endfunction

    task automatic instr(input logic [7:0] tid, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic z);
        cur_tid  = tid;
        cur_op   = op;
        cur_f3   = f3;
        cur_f7   = f7;
        cur_zero = z;
    endtask

    task automatic row(input logic r, input logic m, input logic [21:0] ea, input logic [21:0] eb);
        stim_t s;
        s.tid  = cur_tid;
        s.rst  = r;
        s.op   = cur_op;
        s.f3   = cur_f3;
        s.f7   = cur_f7;
        s.zero = cur_zero;
        s.mr   = m;
        sq.push_back(s);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic row2(input logic [21:0] e);
        row(1'b0, 1'b1, e, e);
    endtask

    task automatic drain();
        stim_t       s;
        logic [21:0] ea;
        logic [21:0] eb;
        int          r;
        r = 0;
        while (sq.size() > 0) begin
            @(negedge clk);
            s = sq.pop_front();
            rst             = s.rst;
            bus_a.op        = s.op;   bus_b.op        = s.op;
            bus_a.f3        = s.f3;   bus_b.f3        = s.f3;
            bus_a.f7        = s.f7;   bus_b.f7        = s.f7;
            bus_a.zero      = s.zero; bus_b.zero      = s.zero;
            bus_a.mem_ready = s.mr;   bus_b.mem_ready = s.mr;
            #1;
            ea = qa.pop_front();
            eb = qb.pop_front();
            check_eq($sformatf("t%0d.r%0d.a", s.tid, r), {10'd0, obs_a}, {10'd0, ea});
            check_eq($sformatf("t%0d.r%0d.b", s.tid, r), {10'd0, obs_b}, {10'd0, eb});
            r++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_a.op = 7'd0; bus_a.f3 = 3'd0; bus_a.f7 = 1'b0; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b1;
        bus_b.op = 7'd0; bus_b.f3 = 3'd0; bus_b.f7 = 1'b0; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b1;
        repeat (3) @(posedge clk);

        // reset state, then lw
        instr(8'd1, 7'b0000011, 3'b010, 1'b0, 1'b0);
        row(1'b1, 1'b1, e_frst(), e_frst());
        row2(e_f()); row2(e_d()); row2(e_madr(1'b0)); row2(e_mrd()); row2(e_mwb());
        drain();

        instr(8'd2, 7'b0110011, 3'b000, 1'b1, 1'b0);   // sub
        row2(e_f()); row2(e_d()); row2(e_exr(3'b001)); row2(e_awb());
        instr(8'd3, 7'b0010011, 3'b000, 1'b1, 1'b0);   // addi with bit30 set stays add
        row2(e_f()); row2(e_d()); row2(e_exi(3'b000)); row2(e_awb());
        instr(8'd4, 7'b0110011, 3'b010, 1'b0, 1'b0);   // slt
        row2(e_f()); row2(e_d()); row2(e_exr(3'b101)); row2(e_awb());
        instr(8'd5, 7'b0010011, 3'b110, 1'b0, 1'b0);   // ori
        row2(e_f()); row2(e_d()); row2(e_exi(3'b011)); row2(e_awb());
        instr(8'd6, 7'b0110011, 3'b111, 1'b0, 1'b0);   // and
        row2(e_f()); row2(e_d()); row2(e_exr(3'b010)); row2(e_awb());
        drain();

        // bne not-equal: taken on a, illegal on b (no bne)
        instr(8'd7, 7'b1100011, 3'b001, 1'b0, 1'b0);
        row2(e_f()); row2(e_d()); row(1'b0, 1'b1, e_br(1'b1), e_br(1'b0));
        instr(8'd8, 7'b1100011, 3'b000, 1'b0, 1'b0);   // beq, not taken
        row(1'b0, 1'b1, e_f(), e_trap()); row(1'b0, 1'b1, e_d(), e_trap()); row(1'b0, 1'b1, e_br(1'b0), e_trap());
        instr(8'd9, 7'b1100011, 3'b000, 1'b0, 1'b1);   // beq, taken
        row(1'b0, 1'b1, e_f(), e_trap()); row(1'b0, 1'b1, e_d(), e_trap()); row(1'b0, 1'b1, e_br(1'b1), e_trap());
        row(1'b1, 1'b1, e_frst(), e_trap());
        drain();

        instr(8'd10, 7'b1101111, 3'b000, 1'b0, 1'b0);  // jal
        row2(e_f()); row2(e_d()); row2(e_jal()); row2(e_awb());
        instr(8'd11, 7'b1100011, 3'b100, 1'b0, 1'b0);  // unsupported branch funct3
        row2(e_f()); row2(e_d()); row2(e_br(1'b0)); row2(e_trap()); row2(e_trap());
        row(1'b1, 1'b1, e_trap(), e_trap());
        drain();

        // sw with three not-ready cycles in MEMWRITE
        instr(8'd12, 7'b0100011, 3'b010, 1'b0, 1'b0);
        row2(e_f()); row2(e_d()); row2(e_madr(1'b1));
        row(1'b0, 1'b0, e_mwr(),      e_mwr());
        row(1'b0, 1'b0, e_f(),        e_mwr());
        row(1'b0, 1'b0, e_d(),        e_mwr());
        row(1'b0, 1'b1, e_madr(1'b1), e_mwr());
        row(1'b0, 1'b1, e_mwr(),      e_f());
        row(1'b1, 1'b1, e_frst(),     e_d());
        drain();

        // reset during a FETCH stall
        instr(8'd13, 7'b0010011, 3'b000, 1'b0, 1'b0);
        row(1'b0, 1'b0, e_f(), e_fstall());
        row(1'b1, 1'b0, e_d(), e_frst());
        drain();

        // illegal opcode, reset out of TRAP, next instruction proceeds
        instr(8'd14, 7'b1111111, 3'b000, 1'b0, 1'b0);
        row2(e_f()); row2(e_d()); row2(e_trap()); row2(e_trap()); row2(e_trap());
        row(1'b1, 1'b1, e_trap(), e_trap());
        instr(8'd15, 7'b0010011, 3'b110, 1'b0, 1'b0);
        row2(e_f()); row2(e_d()); row2(e_exi(3'b011)); row2(e_awb());
        drain();

        // unsupported R-type funct3 traps with no register write
        instr(8'd16, 7'b0110011, 3'b001, 1'b0, 1'b0);
        row2(e_f()); row2(e_d()); row2(e_exr(3'b000)); row2(e_trap());
        row(1'b1, 1'b1, e_trap(), e_trap());
        drain();

        // lw with a two-cycle MEMREAD stall on b
        instr(8'd17, 7'b0000011, 3'b010, 1'b0, 1'b0);
        row2(e_f()); row2(e_d()); row2(e_madr(1'b0));
        row(1'b0, 1'b0, e_mrd(),      e_mrd());
        row(1'b0, 1'b0, e_mwb(),      e_mrd());
        row(1'b0, 1'b1, e_f(),        e_mrd());
        row(1'b0, 1'b1, e_d(),        e_mwb());
        row(1'b1, 1'b1, e_madr(1'b0), e_frst());
        row2(e_f());
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter MEM_WAIT, default 0: 1 = memory states stall on mem_ready; 0 = mem_ready ignored, each memory state lasts one cycle.
REQ-002 Parameter HAS_BNE, default 1: 1 = decode bne (f3=001) besides beq; 0 = bne is illegal.
REQ-003 Parameter STATE_W, default 4: width of the state register and the state debug output.
REQ-004 clk_RV  in  1  single clock; all state changes on rising edge.
REQ-005 reset_RV  in  1  reset, synchronous, active-high.
REQ-006 op  in  7  opcode from the instruction register.
REQ-007 f3  in  3  funct3 from the instruction register.
REQ-008 f7  in  1  bit 30 of the instruction (funct7[5]).
REQ-009 zero  in  1  ALU zero flag from the datapath.
REQ-010 mem_ready  in  1  memory access completes this cycle.
REQ-011 pcWrite  out  1  PC load enable.
REQ-012 adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-013 memRead  out  1  memory read request.
REQ-014 memWrite  out  1  memory write enable.
REQ-015 irWrite  out  1  instruction register (and oldPC) load enable.
REQ-016 resSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-017 aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-018 aluSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
REQ-019 ALUControl  out  3  ALU op: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-020 regWrite  out  1  register file write enable.
REQ-021 inmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-022 illegal  out  1  sticky illegal-instruction flag.
REQ-023 state  out  STATE_W  current state, for debug.

Function
REQ-024 The FSM SHALL have these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
REQ-025 FETCH: memRead=1, adrSrc=0, aluSrcA=00, aluSrcB=10, add, resSrc=10, irWrite=1, pcWrite=1; goes to DECODE.
REQ-026 DECODE: aluSrcA=01, aluSrcB=01, add, inmSrc=10. Next state by op:
  - lw (0000011) or sw (0100011) -> MEMADR
  - R-type (0110011) -> EXECR
  - I-ALU (0010011) -> EXECI
  - branch (1100011) -> BRANCH
  - jal (1101111) -> JAL
  - any other op -> TRAP
REQ-027 MEMADR: aluSrcA=10, aluSrcB=01, add; inmSrc=01 for sw, else 00. Goes to MEMWRITE for sw, MEMREAD for lw.
REQ-028 MEMREAD: memRead=1, adrSrc=1; goes to MEMWB.
REQ-029 MEMWB: resSrc=01, regWrite=1; goes to FETCH.
REQ-030 MEMWRITE: memWrite=1, adrSrc=1; goes to FETCH.
REQ-031 EXECR and EXECI: aluSrcA=10; aluSrcB=00 (EXECR) or 01 (EXECI); go to ALUWB.
REQ-032 ALUWB: resSrc=00, regWrite=1; goes to FETCH.
REQ-033 BRANCH: aluSrcA=10, aluSrcB=00, sub, resSrc=00; goes to FETCH.
  - pcWrite = zero for f3=000.
  - pcWrite = !zero for f3=001 when HAS_BNE=1.
  - Any other f3 goes to TRAP instead, with pcWrite=0.
REQ-034 JAL: aluSrcA=01, aluSrcB=10, add, resSrc=00, pcWrite=1; goes to ALUWB.
REQ-035 ALUControl in EXECR/EXECI SHALL decode f3:
  - 000 = add, or sub when EXECR and f7=1
  - 010 = slt, 110 = or, 111 = and
  - any other f3 -> TRAP next, with regWrite suppressed.
REQ-036 In every state other than REQ-033 and REQ-035, ALUControl SHALL be add when unused.
REQ-037 MEM_WAIT=1: FETCH, MEMREAD and MEMWRITE SHALL hold state while mem_ready=0, with:
  - memRead/memWrite held asserted;
  - irWrite and pcWrite forced to 0;
  - transition and write enables taking effect only in the cycle mem_ready=1.
REQ-038 TRAP SHALL set illegal=1, hold every enable at 0, and remain in TRAP until reset.
REQ-039 All outputs except illegal and state SHALL be combinational decodes of state, op, f3, f7 and zero (Moore plus branch/ALU qualification); there are no output registers.

Reset
REQ-040 reset_RV=1 at a rising edge SHALL load FETCH and clear illegal, from any state, including mid-stall and TRAP.
REQ-041 While reset_RV=1, pcWrite, irWrite, memWrite, memRead and regWrite SHALL be forced to 0.
REQ-042 After reset, all other outputs SHALL take their FETCH values.

Structure
REQ-043 A shared package SHALL hold the state enum, opcode constants, and ALUControl/resSrc/aluSrcA/aluSrcB/inmSrc encodings.
REQ-044 ALU decoding SHALL be a sub-module alu_deco (inputs f3, f7, isR; outputs ALUControl, bad).

Verification
REQ-045 lw with MEM_WAIT=0 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; 5 cycles; regWrite=1 only in cycle 5 with resSrc=01.
REQ-046 sub (op=0110011, f3=000, f7=1) -> ALUControl=001 in EXECR, regWrite=1 in ALUWB, 4 cycles total.
REQ-047 bne with zero=0, then beq with zero=0 -> pcWrite=1 in BRANCH for bne, 0 for beq; HAS_BNE=0 makes bne reach TRAP.
REQ-048 MEM_WAIT=1, sw with mem_ready low for 3 cycles in MEMWRITE -> memWrite high for 4 cycles, then FETCH.
REQ-049 op=1111111 -> TRAP after DECODE, illegal=1 held.
REQ-050 Reset asserted in TRAP, then released -> state=FETCH, illegal=0, next instruction proceeds.
REQ-051 Reset asserted during a FETCH stall -> no enables asserted, state=FETCH.
